// File: rtl/scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : scan_decoder
// Description : Registered SEL_W-to-2**SEL_W decoder with a two-bit enable
//               and selectable output polarity. DIRECT mode decodes iData
//               with one cycle of latency. SCAN mode steps autonomously
//               through the positions enabled in iMask, one step every
//               TICK_DIV clock cycles. Intended as a digit/row strobe source
//               for multiplexed displays.
// Ports       :
//   clk    - system clock, rising edge
//   rst    - asynchronous, active-high reset
//   iEna   - enable; active only when iEna == 2'b10
//   iMode  - 0 = DIRECT decode, 1 = SCAN
//   iData  - select index used in DIRECT mode
//   iMask  - SCAN participation mask, bit k = 1 enables position k
//   oData  - registered strobes, selected bit active (polarity per ACTIVE_LOW)
//   oIndex - registered index currently driven
//   oValid - 1 when exactly one oData position is active
// Revision    : 1.0 - initial release
// ============================================================================
module scan_decoder #(
   parameter int SEL_W      = 3,
   parameter int TICK_DIV   = 50000,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            iEna,
   input  logic                  iMode,
   input  logic [SEL_W-1:0]      iData,
   input  logic [(2**SEL_W)-1:0] iMask,
   output logic [(2**SEL_W)-1:0] oData,
   output logic [SEL_W-1:0]      oIndex,
   output logic                  oValid
);

   localparam int N_OUT   = 2**SEL_W;
   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
   // Idle pattern of the strobe vector; XOR with a one-hot gives the active
   // pattern in either polarity.
   localparam logic [N_OUT-1:0]   INACTIVE   = (ACTIVE_LOW != 0) ? {N_OUT{1'b1}} : {N_OUT{1'b0}};
   localparam logic [N_OUT-1:0]   ONE        = N_OUT'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   state_t               state;
   logic [PRESC_W-1:0]   presc;

   logic                 en;
   logic                 step;
   logic                 found;
   logic [SEL_W-1:0]     cand;
   logic [SEL_W-1:0]     first_idx;
   logic [SEL_W-1:0]     next_idx;
   logic [SEL_W-1:0]     scan_idx;

   assign en   = iEna[1] & ~iEna[0];
   assign step = (presc == PRESC_LAST);

   // Lowest set mask bit, used when SCAN is entered. With an empty mask the
   // index parks at 0 and the strobes stay inactive.
   always_comb begin
      first_idx = '0;
      for (int k = N_OUT - 1; k >= 0; k--) begin
         if (iMask[k]) begin
            first_idx = SEL_W'(k);
         end
      end
   end

   // Next set mask bit above oIndex, searched in priority order from
   // oIndex+1 and wrapping. The last candidate (offset N_OUT) is oIndex
   // itself, so a lone set bit holds; an empty mask also holds.
   always_comb begin
      next_idx = oIndex;
      found    = 1'b0;
      cand     = '0;
      for (int off = 1; off <= N_OUT; off++) begin
         cand = oIndex + SEL_W'(off);
         if (!found && iMask[cand]) begin
            next_idx = cand;
            found    = 1'b1;
         end
      end
   end

   always_comb begin
      if (state != ST_SCAN) begin
         scan_idx = first_idx;
      end else if (step) begin
         scan_idx = next_idx;
      end else begin
         scan_idx = oIndex;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         presc  <= '0;
         oIndex <= '0;
         oData  <= INACTIVE;
         oValid <= 1'b0;
      end else if (!en) begin
         // Index and prescaler deliberately hold while disabled.
         state  <= ST_IDLE;
         oData  <= INACTIVE;
         oValid <= 1'b0;
      end else if (!iMode) begin
         state  <= ST_DIRECT;
         presc  <= '0;
         oIndex <= iData;
         oData  <= INACTIVE ^ (ONE << iData);
         oValid <= 1'b1;
      end else begin
         state <= ST_SCAN;
         if ((state != ST_SCAN) || step) begin
            presc <= '0;
         end else begin
            presc <= presc + PRESC_W'(1);
         end
         oIndex <= scan_idx;
         // A cleared mask bit blanks the strobe immediately while the
         // index keeps its dwell until the next step boundary.
         oValid <= iMask[scan_idx];
         oData  <= iMask[scan_idx] ? (INACTIVE ^ (ONE << scan_idx)) : INACTIVE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_scan_decoder
// Description : Self-checking bench for scan_decoder. Three instances share
//               the stimulus: A (TICK_DIV=4, active low), B (TICK_DIV=4,
//               active high), C (TICK_DIV=1, active low). A behavioural model
//               of dwell/step rules predicts every instance each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_decoder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] ena = 2'b00;
   logic       mode = 1'b0;
   logic [2:0] data = 3'd0;
   logic [7:0] mask = 8'h00;

   logic [7:0] a_data, b_data, c_data;
   logic [2:0] a_idx, b_idx, c_idx;
   logic       a_val, b_val, c_val;

   int checks   = 0;
   int failures = 0;
   bit chk_on   = 1'b0;

   always #5 clk = ~clk;

   scan_decoder #(.SEL_W(3), .TICK_DIV(4), .ACTIVE_LOW(1)) dut_a (
      .clk(clk), .rst(rst), .iEna(ena), .iMode(mode), .iData(data), .iMask(mask),
      .oData(a_data), .oIndex(a_idx), .oValid(a_val));

   scan_decoder #(.SEL_W(3), .TICK_DIV(4), .ACTIVE_LOW(0)) dut_b (
      .clk(clk), .rst(rst), .iEna(ena), .iMode(mode), .iData(data), .iMask(mask),
      .oData(b_data), .oIndex(b_idx), .oValid(b_val));

   scan_decoder #(.SEL_W(3), .TICK_DIV(1), .ACTIVE_LOW(1)) dut_c (
      .clk(clk), .rst(rst), .iEna(ena), .iMode(mode), .iData(data), .iMask(mask),
      .oData(c_data), .oIndex(c_idx), .oValid(c_val));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int  tick_of[3] = '{4, 4, 1};
   int  m_mode[3];            // 0 idle, 1 direct, 2 scan
   int  m_dwell[3];           // cycles already spent on the current scan index
   int  m_idx[3];
   bit  m_on[3];

   function automatic int lowest_set(input logic [7:0] m);
      for (int k = 0; k < 8; k++) if (m[k]) return k;
      return 0;
   endfunction

   function automatic int next_set(input logic [7:0] m, input int cur);
      for (int k = 1; k <= 8; k++) if (m[(cur + k) % 8]) return (cur + k) % 8;
      return cur;
   endfunction

   function automatic logic [7:0] strobes(input bit active_low, input bit on, input int idx);
      logic [7:0] v;
      v = on ? (8'd1 << idx) : 8'd0;
      return active_low ? ~v : v;
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_mode[i] = 0; m_dwell[i] = 0; m_idx[i] = 0; m_on[i] = 1'b0;
         end else if (ena != 2'b10) begin
            m_mode[i] = 0; m_on[i] = 1'b0;
         end else if (!mode) begin
            m_mode[i] = 1; m_idx[i] = int'(data); m_on[i] = 1'b1; m_dwell[i] = 0;
         end else begin
            if (m_mode[i] != 2) begin
               m_dwell[i] = 0;
               m_idx[i]   = lowest_set(mask);
            end else if (m_dwell[i] + 1 >= tick_of[i]) begin
               m_dwell[i] = 0;
               m_idx[i]   = next_set(mask, m_idx[i]);
            end else begin
               m_dwell[i] = m_dwell[i] + 1;
            end
            m_mode[i] = 2;
            m_on[i]   = mask[m_idx[i]];
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on && !rst) begin
         check("A.oData",  32'(a_data), 32'(strobes(1'b1, m_on[0], m_idx[0])));
         check("A.oIndex", 32'(a_idx),  32'(m_idx[0]));
         check("A.oValid", 32'(a_val),  32'(m_on[0]));
         check("B.oData",  32'(b_data), 32'(strobes(1'b0, m_on[1], m_idx[1])));
         check("B.oIndex", 32'(b_idx),  32'(m_idx[1]));
         check("B.oValid", 32'(b_val),  32'(m_on[1]));
         check("C.oData",  32'(c_data), 32'(strobes(1'b1, m_on[2], m_idx[2])));
         check("C.oIndex", 32'(c_idx),  32'(m_idx[2]));
         check("C.oValid", 32'(c_val),  32'(m_on[2]));
      end
   end

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [1:0] ena;
      logic       mode;
      logic [2:0] data;
      logic [7:0] exp_data;
      logic [2:0] exp_idx;
      logic       exp_valid;
   } vec_t;

   vec_t       vecs[12];
   logic [7:0] lo_pat[8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
   int         seq[3]    = '{0, 2, 5};

   initial begin
      for (int k = 0; k < 8; k++) vecs[k] = '{2'b10, 1'b0, 3'(k), lo_pat[k], 3'(k), 1'b1};
      vecs[8]  = '{2'b00, 1'b0, 3'd3, 8'hFF, 3'd7, 1'b0};
      vecs[9]  = '{2'b01, 1'b0, 3'd5, 8'hFF, 3'd7, 1'b0};
      vecs[10] = '{2'b11, 1'b0, 3'd1, 8'hFF, 3'd7, 1'b0};
      vecs[11] = '{2'b10, 1'b0, 3'd2, 8'hFB, 3'd2, 1'b1};

      // Reset values, checked before any clock edge.
      #2 rst = 1'b1;
      #1;
      check("reset.A.oData",  32'(a_data), 32'h0FF);
      check("reset.B.oData",  32'(b_data), 32'h000);
      check("reset.A.oIndex", 32'(a_idx),  32'd0);
      check("reset.A.oValid", 32'(a_val),  32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk_on = 1'b1;

      // DIRECT sweep and disable encodings.
      for (int i = 0; i < 12; i++) begin
         ena = vecs[i].ena; mode = vecs[i].mode; data = vecs[i].data;
         @(negedge clk);
         check($sformatf("vec%0d.oData", i),  32'(a_data), 32'(vecs[i].exp_data));
         check($sformatf("vec%0d.oIndex", i), 32'(a_idx),  32'(vecs[i].exp_idx));
         check($sformatf("vec%0d.oValid", i), 32'(a_val),  32'(vecs[i].exp_valid));
      end

      // SCAN over mask 0010_0101: 0,2,5,0 each held four cycles.
      mode = 1'b1; mask = 8'b0010_0101;
      for (int c = 0; c < 13; c++) begin
         @(negedge clk);
         check($sformatf("scan_seq%0d.oIndex", c), 32'(a_idx), 32'(seq[(c / 4) % 3]));
      end

      // Empty mask blanks the strobes; setting bit 3 resumes at index 3.
      mask = 8'h00;
      @(negedge clk);
      check("mask0.oData",  32'(a_data), 32'h0FF);
      check("mask0.oValid", 32'(a_val),  32'd0);
      mask = 8'h08;
      begin
         bit hit = 1'b0;
         for (int c = 0; c < 6 && !hit; c++) begin
            @(negedge clk);
            if (a_idx == 3'd3 && a_data == 8'hF7) hit = 1'b1;
         end
         check("mask8.reached_idx3", 32'(hit), 32'd1);
      end
      repeat (8) @(negedge clk);
      check("mask8.hold.oData", 32'(a_data), 32'h0F7);

      // Active-high walk over a full mask, entered fresh through IDLE.
      ena = 2'b00;
      @(negedge clk);
      ena = 2'b10; mask = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         logic [7:0] w;
         w = 8'd1 << (k % 8);
         @(negedge clk);
         check($sformatf("walk%0d.B.oData", k), 32'(b_data), 32'(w));
         repeat (3) @(negedge clk);
      end

      // Asynchronous reset in mid-dwell, observed with no clock edge.
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("async_rst.B.oData",  32'(b_data), 32'd0);
      check("async_rst.B.oIndex", 32'(b_idx),  32'd0);
      check("async_rst.B.oValid", 32'(b_val),  32'd0);
      check("async_rst.A.oData",  32'(a_data), 32'h0FF);
      @(negedge clk);
      ena = 2'b00;
      @(negedge clk);
      rst = 1'b0;

      // DIRECT 6 then SCAN with mask C0: index 6 for four cycles, then 7.
      ena = 2'b10; mode = 1'b0; data = 3'd6; mask = 8'hC0;
      @(negedge clk);
      mode = 1'b1;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         check($sformatf("d2s%0d.A.oIndex", c), 32'(a_idx), (c < 4 || c >= 8) ? 32'd6 : 32'd7);
      end

      // Randomised traffic checked cycle-by-cycle against the model.
      for (int n = 0; n < 600; n++) begin
         @(negedge clk);
         ena  = ($urandom_range(0, 7) < 6) ? 2'b10 : 2'($urandom);
         if ($urandom_range(0, 7) == 0) mode = ~mode;
         data = 3'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            case ($urandom_range(0, 3))
               0:       mask = 8'h00;
               1:       mask = 8'd1 << $urandom_range(0, 7);
               default: mask = 8'($urandom);
            endcase
         end
      end
      @(negedge clk);
      chk_on = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
Parametrised, registered N-to-2^N decoder with a two-bit enable and selectable output polarity.
In DIRECT mode it decodes iData into a one-hot (or one-cold) output vector with one cycle of latency.
In SCAN mode it steps through the outputs autonomously on a prescaled tick, skipping positions cleared in iMask.
Intended as the digit or row strobe source for multiplexed seven-segment and LED-matrix displays on the lab boards.

Parameters:
SEL_W, 3, select width; output width N_OUT = 2**SEL_W (localparam)
TICK_DIV, 50000, clock cycles per scan step; legal range 1..2**24
ACTIVE_LOW, 1, 1: selected output driven 0 and others 1; 0: one-hot high

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
iEna  input  2  enable; block is enabled only when iEna[1]=1 and iEna[0]=0
iMode  input  1  0 = DIRECT decode, 1 = SCAN
iData  input  SEL_W  select index used in DIRECT mode
iMask  input  N_OUT  SCAN mode: bit k=1 means position k participates
oData  output  N_OUT  registered decoded strobes, polarity per ACTIVE_LOW
oIndex  output  SEL_W  registered index currently driven
oValid  output  1  1 when exactly one oData position is active

Behaviour:
- Reset (async, while rst=1):
  - oData = all inactive (all 1s if ACTIVE_LOW=1, else all 0s).
  - oIndex = 0, oValid = 0.
  - Prescaler = 0, state = IDLE.
- en = iEna[1] & ~iEna[0]. States: IDLE, DIRECT, SCAN. State is re-evaluated every cycle from en and iMode:
  - en=0 -> IDLE.
  - en=1, iMode=0 -> DIRECT.
  - en=1, iMode=1 -> SCAN.
- IDLE:
  - Next cycle: oData all inactive, oValid=0.
  - oIndex and prescaler hold their values.
- DIRECT:
  - oData[iData] active and all other bits inactive, registered one cycle after the inputs are sampled.
  - oIndex = iData, oValid = 1.
  - Prescaler held at 0.
- SCAN entry (from IDLE or DIRECT):
  - Prescaler cleared to 0.
  - oIndex = lowest k with iMask[k]=1, driven on the first SCAN cycle.
- SCAN step:
  - Prescaler counts 0..TICK_DIV-1 and wraps.
  - On the cycle it equals TICK_DIV-1, the index advances to the next set mask bit above oIndex, wrapping modulo N_OUT.
  - The search is combinational and priority-ordered, starting from oIndex+1.
  - If oIndex is the only set bit, the index holds.
  - Each index is therefore held for exactly TICK_DIV cycles.
- SCAN, iMask all zero:
  - oData all inactive, oValid=0.
  - Prescaler keeps running; oIndex holds.
  - When a mask bit is set again, the next step (or the same-cycle re-evaluation, if the current index is now set) resumes normally.
- SCAN, iMask[oIndex] cleared mid-dwell:
  - oData goes inactive the next cycle and oValid=0.
  - The advance happens at the normal step boundary.
- TICK_DIV=1: the index advances every cycle.
- Mode change or disable takes effect on the next clock edge, with no extra latency.
- Returning to SCAN from IDLE follows the SCAN entry rule; the held oIndex is not resumed.
- Reset asserted mid-dwell: all registers return to their reset values immediately (asynchronously), not on the next edge.
- Exactly zero or one oData bit is active at any time. A glitch-free one-hot register is required; oData is never decoded combinationally at the port.
- Prescaler width is clog2(TICK_DIV), with a minimum of 1.

Test Plan:
- SEL_W=3, ACTIVE_LOW=1, iEna=2'b10, iMode=0, iData sweeps 0..7 -> one cycle later oData = 8'hFE, FD, FB, F7, EF, DF, BF, 7F; oIndex tracks iData; oValid=1.
- iEna in {00, 01, 11} with any iData -> oData=8'hFF and oValid=0 on the next cycle; iEna back to 10 -> decode resumes after 1 cycle.
- TICK_DIV=4, iMode=1, iMask=8'b0010_0101 -> oIndex sequence 0, 2, 5, 0, 2, ..., each held exactly 4 cycles; oData goes 8'hFE, FB, DF, FE.
- SCAN with iMask=8'h00 -> oData=8'hFF, oValid=0; then set iMask=8'h08 -> oIndex=3, oData=8'hF7 within at most TICK_DIV cycles and held thereafter.
- ACTIVE_LOW=0, SCAN, iMask=8'hFF -> oData walks 01, 02, 04, ..., 80, 01 (wrap); assert rst mid-dwell -> oData=0, oIndex=0, oValid=0 immediately, with no clock edge needed.
- Switch DIRECT (iData=6) -> SCAN with iMask=8'hC0 -> first SCAN cycle oIndex=6, prescaler=0; advances to 7 after exactly TICK_DIV cycles.
